mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the EX stage and the MEM/WB pipeline register. It latches the EX result under a valid/allowin handshake and captures the synchronous data-RAM read data. That read data returns in the instruction's first MEM cycle, and the stage holds it across WB back-pressure. It then aligns and extends load data, and produces the final write-back value and the MEM-stage forwarding bus. Its outputs drive the MEM/WB register directly, with `mem_to_wb_valid` serving as that register's `mem_ready_go`.

## Interface
Parameters:
- none. All widths are fixed at 32-bit data and 5-bit register index.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `ex_to_mem_valid`  in  1  EX holds a finished instruction
- `mem_allowin`  out  1  MEM can accept an instruction this cycle
- `ex_pc`  in  32  instruction PC
- `ex_alu_result`  in  32  ALU result, or memory address for loads and stores
- `ex_rf_we`  in  1  writes the register file
- `ex_rd`  in  5  destination register
- `ex_res_from_dram`  in  1  instruction is a load
- `ex_load_op`  in  3  load type, see Operation
- `ex_dram_we`, `ex_dram_waddr`, `ex_dram_wdata`  in  1/32/32  store info, passed through for trace
- `dram_rdata`  in  32  data-RAM read data; valid only in the instruction's first MEM cycle
- `wb_allowin`  in  1  the MEM/WB register can accept
- `flush`  in  1  kill the instruction in MEM
- `mem_valid`  out  1  MEM holds a live instruction
- `mem_to_wb_valid`  out  1  instruction leaves MEM this cycle, i.e. `mem_ready_go` for the WB register
- `mem_pc`, `mem_alu_result`, `mem_rd`, `mem_ref_we`, `mem_res_from_dram`, `mem_dram_we`, `mem_dram_waddr`, `mem_dram_wdata`  out  latched copies of the EX inputs
- `mem_dram_rdata`  out  32  aligned and extended load data
- `mem_final_result`  out  32  `mem_dram_rdata` if the instruction is a load, else `mem_alu_result`
- `mem_fwd_we`  out  1  `mem_valid & mem_ref_we & (mem_rd != 0)`
- `mem_fwd_rd`  out  5  equals `mem_rd`
- `mem_fwd_data`  out  32  equals `mem_final_result`

## Operation
- **Handshake.**
  - `mem_ready_go` is internal and fixed at 1.
  - `mem_allowin = !mem_valid | wb_allowin`.
  - `mem_to_wb_valid = mem_valid & wb_allowin & !flush`.
- **Latch.** When `ex_to_mem_valid & mem_allowin & !flush`, the stage loads every `ex_*` field, sets `mem_valid=1` and sets `first=1`.
  - If the latch condition is false and the instruction leaves (`mem_valid & wb_allowin`), `mem_valid` clears to 0.
- **Flush.** `flush` forces `mem_valid=0` next cycle and has priority over a simultaneous latch. `hold_valid` clears at the same time.
- **Read-data capture.** The stage keeps a `first` flag, a `rdata_hold` register and a `hold_valid` flag.
  - Raw data is `dram_rdata` when `first=1`, otherwise `rdata_hold`.
  - When `first=1` and the instruction does not leave, the stage writes `rdata_hold<=dram_rdata` and sets `hold_valid=1`.
  - `first` clears after one cycle unless a new instruction is latched.
- **Load alignment.** The byte offset is `mem_alu_result[1:0]`.
  - `000` ld.w: raw word.
  - `001` ld.b: byte at the offset, sign-extended.
  - `011` ld.bu: byte at the offset, zero-extended.
  - `010` ld.h: halfword selected by `off[1]`, sign-extended; `off[0]` is ignored.
  - `100` ld.hu: halfword selected by `off[1]`, zero-extended.
  - `101`–`111`: treated as ld.w.
- **Outputs.** Latched fields are output even when `mem_valid=0`. Consumers must qualify them with `mem_valid` or `mem_to_wb_valid`.

## Timing
- **Reset.** All outputs and internal registers are 0: `mem_valid`, `first`, `hold_valid`, `rdata_hold` and every latched field. `mem_allowin=1`.
- **Latency.** One cycle from EX latch to availability at WB when `wb_allowin=1`.
- **Throughput.** Back-to-back loads sustain one instruction per cycle.
- **WB stall.** If WB stalls N cycles, the outputs stay stable for N+1 cycles and `mem_dram_rdata` stays constant.
- **Data-RAM timing.** `dram_rdata` may change arbitrarily after the first MEM cycle.
- **Reset mid-stall.** Reset while an instruction is stalled discards it with no `mem_to_wb_valid` pulse.
- **Leave and refill.** Leave and refill in the same cycle is allowed: the next instruction latches while the current one is captured by the WB register.

## Structure
- A shared package, `cpu_defs`, holds:
  - the `LOAD_W/B/H/BU/HU` 3-bit encodings;
  - the width constants for data and register index.
- Sub-module `load_align` is combinational: raw word, offset and `load_op` in, extended data out.
- The handshake and hold registers stay in `mem_stage`.

## Test plan
- **Reset.** Drive `rst=1` for 2 cycles → `mem_valid=0`, `mem_allowin=1`, all outputs 0.
- **ld.b.** Address `0x1003`, `dram_rdata=0x80FF_1234`, `wb_allowin=1` → next cycle `mem_dram_rdata=0xFFFF_FF80`, `mem_to_wb_valid=1`.
- **ld.hu under stall.** Address `0x2002`, `dram_rdata=0xBEEF_0000` in cycle 1, then `dram_rdata=0` with `wb_allowin=0` for 3 cycles → `mem_dram_rdata=0x0000_BEEF` throughout, `mem_allowin=0`, a single `mem_to_wb_valid` pulse on release.
- **ALU forwarding.** ALU instruction with `rd=5`, result `0x1234` → `mem_fwd_we=1`, `mem_fwd_data=0x1234`; the same instruction with `rd=0` → `mem_fwd_we=0`.
- **Flush priority.** Assert `flush` in the same cycle as `ex_to_mem_valid` → next cycle `mem_valid=0`, no `mem_to_wb_valid`.
- **Back-to-back ld.w.** Three ld.w with `rdata` A, B, C and `wb_allowin=1` → `mem_final_result` shows A, B, C on consecutive cycles.

Source files
------------

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, load encodings and MEM-stage field record
// Contents: DATA_W/REG_W widths, LOAD_* 3-bit load-type codes,
//           mem_fields_t (the EX fields latched by the MEM stage).
package cpu_defs;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [2:0] LOAD_W  = 3'b000;
    localparam logic [2:0] LOAD_B  = 3'b001;
    localparam logic [2:0] LOAD_H  = 3'b010;
    localparam logic [2:0] LOAD_BU = 3'b011;
    localparam logic [2:0] LOAD_HU = 3'b100;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] alu_result;
        logic              rf_we;
        logic [REG_W-1:0]  rd;
        logic              res_from_dram;
        logic [2:0]        load_op;
        logic              dram_we;
        logic [DATA_W-1:0] dram_waddr;
        logic [DATA_W-1:0] dram_wdata;
    } mem_fields_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load data alignment and extension
// Ports: raw (32-bit read word), offset (byte address bits [1:0]),
//        load_op (LOAD_* code), data (aligned, extended result).
module load_align
    import cpu_defs::*;
(
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        offset,
    input  logic [2:0]        load_op,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (offset)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
    end

    // Halfword loads ignore offset[0]; a misaligned address just picks the enclosing half.
    assign half_sel = offset[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        data = raw;
        case (load_op)
            LOAD_B:  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_BU: data = {24'd0, byte_sel};
            LOAD_H:  data = {{16{half_sel[15]}}, half_sel};
            LOAD_HU: data = {16'd0, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between EX and MEM/WB
// Ports: clk/rst (sync, active-high); EX side ex_to_mem_valid/mem_allowin and ex_* fields;
//        dram_rdata (valid in first MEM cycle only); WB side wb_allowin, flush;
//        outputs mem_valid, mem_to_wb_valid, latched mem_* fields, aligned mem_dram_rdata,
//        mem_final_result and the mem_fwd_* forwarding bus.
module mem_stage
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_to_mem_valid,
    output logic              mem_allowin,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_rf_we,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_res_from_dram,
    input  logic [2:0]        ex_load_op,
    input  logic              ex_dram_we,
    input  logic [DATA_W-1:0] ex_dram_waddr,
    input  logic [DATA_W-1:0] ex_dram_wdata,
    input  logic [DATA_W-1:0] dram_rdata,
    input  logic              wb_allowin,
    input  logic              flush,
    output logic              mem_valid,
    output logic              mem_to_wb_valid,
    output logic [DATA_W-1:0] mem_pc,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_ref_we,
    output logic              mem_res_from_dram,
    output logic              mem_dram_we,
    output logic [DATA_W-1:0] mem_dram_waddr,
    output logic [DATA_W-1:0] mem_dram_wdata,
    output logic [DATA_W-1:0] mem_dram_rdata,
    output logic [DATA_W-1:0] mem_final_result,
    output logic              mem_fwd_we,
    output logic [REG_W-1:0]  mem_fwd_rd,
    output logic [DATA_W-1:0] mem_fwd_data
);

    mem_fields_t       fields;
    logic              first;
    logic              hold_valid;
    logic [DATA_W-1:0] rdata_hold;
    logic [DATA_W-1:0] raw;
    logic              leave;
    logic              latch;

    // The stage always completes in one cycle, so readiness reduces to WB acceptance.
    assign mem_allowin     = !mem_valid | wb_allowin;
    assign leave           = mem_valid & wb_allowin;
    assign latch           = ex_to_mem_valid & mem_allowin & !flush;
    assign mem_to_wb_valid = mem_valid & wb_allowin & !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid  <= 1'b0;
            first      <= 1'b0;
            hold_valid <= 1'b0;
            rdata_hold <= '0;
            fields     <= '0;
        end else begin
            if (flush)
                mem_valid <= 1'b0;
            else if (latch)
                mem_valid <= 1'b1;
            else if (leave)
                mem_valid <= 1'b0;

            first <= latch;

            if (latch) begin
                fields.pc            <= ex_pc;
                fields.alu_result    <= ex_alu_result;
                fields.rf_we         <= ex_rf_we;
                fields.rd            <= ex_rd;
                fields.res_from_dram <= ex_res_from_dram;
                fields.load_op       <= ex_load_op;
                fields.dram_we       <= ex_dram_we;
                fields.dram_waddr    <= ex_dram_waddr;
                fields.dram_wdata    <= ex_dram_wdata;
            end

            // The RAM only presents data in the first MEM cycle; keep it if WB stalls us.
            if (first && !leave)
                rdata_hold <= dram_rdata;

            if (flush || latch)
                hold_valid <= 1'b0;
            else if (first && !leave)
                hold_valid <= 1'b1;
        end
    end

    // Without a captured word the raw data reads as zero, keeping idle outputs quiet.
    assign raw = first ? dram_rdata : (hold_valid ? rdata_hold : '0);

    load_align u_load_align (
        .raw     (raw),
        .offset  (fields.alu_result[1:0]),
        .load_op (fields.load_op),
        .data    (mem_dram_rdata)
    );

    assign mem_pc            = fields.pc;
    assign mem_alu_result    = fields.alu_result;
    assign mem_rd            = fields.rd;
    assign mem_ref_we        = fields.rf_we;
    assign mem_res_from_dram = fields.res_from_dram;
    assign mem_dram_we       = fields.dram_we;
    assign mem_dram_waddr    = fields.dram_waddr;
    assign mem_dram_wdata    = fields.dram_wdata;

    assign mem_final_result = fields.res_from_dram ? mem_dram_rdata : fields.alu_result;
    assign mem_fwd_we       = mem_valid & fields.rf_we & (fields.rd != '0);
    assign mem_fwd_rd       = fields.rd;
    assign mem_fwd_data     = mem_final_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] ex_pc, ex_alu_result;
    logic        ex_rf_we;
    logic [4:0]  ex_rd;
    logic        ex_res_from_dram;
    logic [2:0]  ex_load_op;
    logic        ex_dram_we;
    logic [31:0] ex_dram_waddr, ex_dram_wdata;
    logic [31:0] dram_rdata = 32'd0;
    logic        wb_allowin, flush;
    logic        mem_valid, mem_to_wb_valid;
    logic [31:0] mem_pc, mem_alu_result;
    logic [4:0]  mem_rd;
    logic        mem_ref_we, mem_res_from_dram, mem_dram_we;
    logic [31:0] mem_dram_waddr, mem_dram_wdata, mem_dram_rdata, mem_final_result;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
        .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_rf_we(ex_rf_we), .ex_rd(ex_rd),
        .ex_res_from_dram(ex_res_from_dram), .ex_load_op(ex_load_op),
        .ex_dram_we(ex_dram_we), .ex_dram_waddr(ex_dram_waddr), .ex_dram_wdata(ex_dram_wdata),
        .dram_rdata(dram_rdata), .wb_allowin(wb_allowin), .flush(flush),
        .mem_valid(mem_valid), .mem_to_wb_valid(mem_to_wb_valid),
        .mem_pc(mem_pc), .mem_alu_result(mem_alu_result), .mem_rd(mem_rd),
        .mem_ref_we(mem_ref_we), .mem_res_from_dram(mem_res_from_dram),
        .mem_dram_we(mem_dram_we), .mem_dram_waddr(mem_dram_waddr), .mem_dram_wdata(mem_dram_wdata),
        .mem_dram_rdata(mem_dram_rdata), .mem_final_result(mem_final_result),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result from the memory word by arithmetic on byte/half values.
    function automatic logic [31:0] expect_load(input logic [31:0] w, input logic [1:0] off,
                                                input logic [2:0] op);
        logic [31:0] b, h;
        b = (w >> (int'(off) * 8)) & 32'hFF;
        h = (w >> ((int'(off) / 2) * 16)) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd3:    return b;
            3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    // Model: which instruction occupies MEM and the memory word it was given.
    logic [31:0] cur_word;
    logic        m_valid = 1'b0, m_first = 1'b0;
    logic [31:0] m_pc = 0, m_alu = 0, m_waddr = 0, m_wdata = 0, m_word = 0;
    logic        m_rf_we = 0, m_load = 0, m_dwe = 0;
    logic [4:0]  m_rd = 0;
    logic [2:0]  m_op = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 0; m_first <= 0; m_pc <= 0; m_alu <= 0; m_waddr <= 0; m_wdata <= 0;
            m_word <= 0; m_rf_we <= 0; m_load <= 0; m_dwe <= 0; m_rd <= 0; m_op <= 0;
        end else if (flush) begin
            m_valid <= 0; m_first <= 0;
        end else if (ex_to_mem_valid && (!m_valid || wb_allowin)) begin
            m_valid <= 1; m_first <= 1;
            m_pc <= ex_pc; m_alu <= ex_alu_result; m_rf_we <= ex_rf_we; m_rd <= ex_rd;
            m_load <= ex_res_from_dram; m_op <= ex_load_op; m_dwe <= ex_dram_we;
            m_waddr <= ex_dram_waddr; m_wdata <= ex_dram_wdata; m_word <= cur_word;
        end else begin
            m_first <= 0;
            if (m_valid && wb_allowin) m_valid <= 0;
        end
    end

    // The RAM presents the word only in the first MEM cycle, noise otherwise.
    always @(posedge clk) begin
        #1;
        dram_rdata = m_first ? m_word : $urandom;
    end

    always @(negedge clk) begin
        chk("mem_valid", mem_valid, m_valid);
        chk("mem_allowin", mem_allowin, !m_valid || wb_allowin);
        chk("mem_to_wb_valid", mem_to_wb_valid, m_valid && wb_allowin && !flush);
        chk("mem_pc", mem_pc, m_pc);
        chk("mem_alu_result", mem_alu_result, m_alu);
        chk("mem_rd", mem_rd, m_rd);
        chk("mem_ref_we", mem_ref_we, m_rf_we);
        chk("mem_res_from_dram", mem_res_from_dram, m_load);
        chk("mem_dram_we", mem_dram_we, m_dwe);
        chk("mem_dram_waddr", mem_dram_waddr, m_waddr);
        chk("mem_dram_wdata", mem_dram_wdata, m_wdata);
        chk("mem_fwd_we", mem_fwd_we, m_valid && m_rf_we && (m_rd != 0));
        chk("mem_fwd_rd", mem_fwd_rd, m_rd);
        if (m_valid) begin
            chk("mem_dram_rdata", mem_dram_rdata, expect_load(m_word, m_alu[1:0], m_op));
            chk("mem_final_result", mem_final_result,
                m_load ? expect_load(m_word, m_alu[1:0], m_op) : m_alu);
            chk("mem_fwd_data", mem_fwd_data,
                m_load ? expect_load(m_word, m_alu[1:0], m_op) : m_alu);
        end
    end

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] addr, input logic rf_we,
                          input logic [4:0] rd, input logic load, input logic [2:0] op,
                          input logic [31:0] word, input logic dwe);
        ex_pc = pc; ex_alu_result = addr; ex_rf_we = rf_we; ex_rd = rd;
        ex_res_from_dram = load; ex_load_op = op; ex_dram_we = dwe;
        ex_dram_waddr = addr; ex_dram_wdata = ~pc; cur_word = word;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t_addr [8] = '{32'h6000, 32'h6001, 32'h6002, 32'h6005, 32'h6006, 32'h6008, 32'h600B, 32'h600C};
    logic [2:0]  t_op   [8] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd1, 3'd5, 3'd7, 3'd0};
    logic [31:0] t_word [8] = '{32'h1234_8765, 32'h1234_8765, 32'h8765_1234, 32'h0000_F100,
                                32'h007F_0000, 32'hCAFE_F00D, 32'h0102_0304, 32'h5A5A_5A5A};

    initial begin
        int pulses;
        int guard;
        logic acc;
        rst = 1; ex_to_mem_valid = 0; wb_allowin = 0; flush = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", mem_valid, 0);
        chk("rst_allowin", mem_allowin, 1);
        chk("rst_pc", mem_pc, 0);
        chk("rst_rdata", mem_dram_rdata, 0);
        chk("rst_final", mem_final_result, 0);
        chk("rst_fwd_we", mem_fwd_we, 0);
        rst = 0;
        tick;

        // ld.b at byte 3
        set_ex(32'h100, 32'h1003, 1, 3, 1, 3'b001, 32'h80FF_1234, 0);
        ex_to_mem_valid = 1; wb_allowin = 1;
        tick; ex_to_mem_valid = 0; #1;
        chk("ldb_rdata", mem_dram_rdata, 32'hFFFF_FF80);
        chk("ldb_to_wb", mem_to_wb_valid, 1);
        tick;

        // ld.hu held through a 3-cycle WB stall
        set_ex(32'h104, 32'h2002, 1, 4, 1, 3'b100, 32'hBEEF_0000, 0);
        ex_to_mem_valid = 1;
        tick; ex_to_mem_valid = 0; wb_allowin = 0; pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldhu_stall_rdata", mem_dram_rdata, 32'h0000_BEEF);
            chk("ldhu_stall_allowin", mem_allowin, 0);
            pulses += int'(mem_to_wb_valid);
            tick;
        end
        wb_allowin = 1; #1;
        chk("ldhu_release_rdata", mem_dram_rdata, 32'h0000_BEEF);
        pulses += int'(mem_to_wb_valid);
        tick; #1;
        pulses += int'(mem_to_wb_valid);
        chk("ldhu_pulses", pulses, 1);
        tick;

        // ALU forwarding, rd=5 then rd=0
        set_ex(32'h108, 32'h1234, 1, 5, 0, 0, 32'hDEAD_BEEF, 0);
        ex_to_mem_valid = 1;
        tick;
        set_ex(32'h10C, 32'h1234, 1, 0, 0, 0, 32'hDEAD_BEEF, 0);
        #1;
        chk("fwd_we_rd5", mem_fwd_we, 1);
        chk("fwd_data_rd5", mem_fwd_data, 32'h1234);
        tick; ex_to_mem_valid = 0; #1;
        chk("fwd_we_rd0", mem_fwd_we, 0);
        chk("fwd_data_rd0", mem_fwd_data, 32'h1234);
        tick;

        // flush wins over a simultaneous latch
        set_ex(32'h110, 32'h3000, 1, 7, 1, 0, 32'h1111_2222, 0);
        ex_to_mem_valid = 1; flush = 1;
        tick; ex_to_mem_valid = 0; flush = 0; #1;
        chk("flush_valid", mem_valid, 0);
        chk("flush_to_wb", mem_to_wb_valid, 0);
        chk("flush_pc_kept", mem_pc, 32'h10C);
        tick;

        // flush of a stalled ld.bu
        set_ex(32'h114, 32'h3001, 1, 8, 1, 3'b011, 32'h0000_AB00, 0);
        ex_to_mem_valid = 1; wb_allowin = 0;
        tick; ex_to_mem_valid = 0; #1;
        chk("ldbu_rdata", mem_dram_rdata, 32'h0000_00AB);
        tick; wb_allowin = 1; flush = 1; #1;
        chk("stall_flush_to_wb", mem_to_wb_valid, 0);
        tick; flush = 0; #1;
        chk("stall_flush_valid", mem_valid, 0);
        tick;

        // back-to-back ld.w
        set_ex(32'h120, 32'h4000, 1, 10, 1, 0, 32'hA0A0_A0A1, 0);
        ex_to_mem_valid = 1;
        tick;
        set_ex(32'h124, 32'h4004, 1, 11, 1, 0, 32'hB0B0_B0B2, 0); #1;
        chk("b2b_A", mem_final_result, 32'hA0A0_A0A1);
        tick;
        set_ex(32'h128, 32'h4008, 1, 12, 1, 0, 32'hC0C0_C0C3, 0); #1;
        chk("b2b_B", mem_final_result, 32'hB0B0_B0B2);
        tick; ex_to_mem_valid = 0; #1;
        chk("b2b_C", mem_final_result, 32'hC0C0_C0C3);
        tick;

        // mixed loads and a store under random WB back-pressure
        for (int k = 0; k < 8; k++) begin
            set_ex(32'h300 + 32'(k * 4), t_addr[k], 1, 5'(k + 13), (k != 7), t_op[k], t_word[k], (k == 7));
            ex_to_mem_valid = 1;
            guard = 0;
            do begin
                wb_allowin = 1'($urandom_range(0, 1));
                acc = !m_valid || wb_allowin;
                tick;
                guard++;
            end while (!acc && guard < 50);
            if (!acc) chk("accept_timeout", 0, 1);
        end
        ex_to_mem_valid = 0; wb_allowin = 1;
        tick; tick;

        // reset while stalled drops the instruction silently
        set_ex(32'h200, 32'h5000, 1, 9, 1, 0, 32'h5555_AAAA, 0);
        ex_to_mem_valid = 1; wb_allowin = 0;
        tick; ex_to_mem_valid = 0;
        tick; rst = 1; #1;
        chk("rst_stall_to_wb", mem_to_wb_valid, 0);
        tick; rst = 0; wb_allowin = 1; #1;
        chk("rst_stall_valid", mem_valid, 0);
        chk("rst_stall_to_wb_after", mem_to_wb_valid, 0);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
